// File: rtl/sy_ppl_instr_queue_pkg.sv
// Shared types for the instruction queue between the realigner and decode.
package sy_ppl_instr_queue_pkg;

  localparam int unsigned SY_IQ_DEPTH = 8;

  // One queued instruction; compr is computed once at push time.
  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        compr;
  } sy_iq_entry_t;

  // A 32-bit encoding always has 2'b11 in its two lowest bits.
  function automatic logic sy_is_compr(input logic [31:0] instr);
    return instr[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/sy_ppl_instr_queue.sv
// Instruction queue: takes up to INSTR_PER_FETCH realigned instructions per
// cycle, keeps them in order and hands them to decode one per cycle.
module sy_ppl_instr_queue
  import sy_ppl_instr_queue_pkg::*;
#(
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned DEPTH           = SY_IQ_DEPTH
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic [INSTR_PER_FETCH-1:0]        valid_i,
  input  logic [INSTR_PER_FETCH-1:0][63:0]  addr_i,
  input  logic [INSTR_PER_FETCH-1:0][31:0]  instr_i,
  output logic                              ready_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [63:0]                       addr_o,
  output logic [31:0]                       instr_o,
  output logic                              is_compr_o,
  output logic [$clog2(DEPTH):0]            count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] npush;
  logic             push_en, pop_en;

  sy_iq_entry_t     mem_reg    [DEPTH];
  sy_iq_entry_t     lane_entry [INSTR_PER_FETCH];
  logic [PTR_W-1:0] lane_slot  [INSTR_PER_FETCH];
  sy_iq_entry_t     head;

  // Per-lane entry formatting.
  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_lane
    assign lane_entry[gi] = '{addr:  addr_i[gi],
                              instr: instr_i[gi],
                              compr: sy_is_compr(instr_i[gi])};
  end

  // Compaction: each valid lane lands after all lower valid lanes; npush is the popcount.
  always_comb begin
    npush = '0;
    for (int l = 0; l < int'(INSTR_PER_FETCH); l++) begin
      lane_slot[l] = wr_ptr_reg + npush[PTR_W-1:0];
      if (valid_i[l]) npush = npush + CNT_W'(1);
    end
  end

  // Handshake and next-state arithmetic; ready depends on registered count only.
  always_comb begin
    ready_o     = (CNT_W'(DEPTH) - count_reg) >= CNT_W'(INSTR_PER_FETCH);
    valid_o     = (count_reg != '0) & ~flush_i;
    push_en     = ready_o & (|valid_i) & ~flush_i;
    pop_en      = valid_o & ready_i;
    wr_ptr_next = wr_ptr_reg + (push_en ? npush[PTR_W-1:0] : '0);
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop_en);
    count_next  = count_reg + (push_en ? npush : '0) - CNT_W'(pop_en);
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage; a flush leaves contents in place, only the pointers move.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int j = 0; j < int'(DEPTH); j++) mem_reg[j] <= '0;
    end else if (push_en) begin
      for (int l = 0; l < int'(INSTR_PER_FETCH); l++) begin
        if (valid_i[l]) mem_reg[lane_slot[l]] <= lane_entry[l];
      end
    end
  end

  assign head       = mem_reg[rd_ptr_reg];
  assign addr_o     = head.addr;
  assign instr_o    = head.instr;
  assign is_compr_o = head.compr;
  assign count_o    = count_reg;

  // Lanes offered while the queue cannot take a full fetch are lost.
  a_no_drop : assert property (@(posedge clk_i) disable iff (!rst_ni)
                               ((|valid_i) & ~flush_i) |-> ready_o);

  // Occupancy can never pass DEPTH.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   count_reg <= CNT_W'(DEPTH));

endmodule
